// File: rtl/spi_cmd_ram.sv
// Command-decoded single-port RAM behind an SPI slave: SET_WR / WRITE / SET_RD / READ.
// Define SPI_RAM_AUTO_INC_EN to auto-increment the write/read addresses after each WRITE/READ.
module spi_cmd_ram #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              err
);

  localparam logic [1:0] OP_SET_WR = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_SET_RD = 2'b10;
  localparam logic [1:0] OP_READ   = 2'b11;

  // One extra bit so MEM_DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

  logic [1:0]        op;
  logic [DATA_W-1:0] payload;
  logic [ADDR_W-1:0] wr_add_reg;
  logic [ADDR_W-1:0] wr_add_next;
  logic [ADDR_W-1:0] rd_add_reg;
  logic [ADDR_W-1:0] rd_add_next;
  logic              do_write;
  logic              do_read;
  logic              wr_in_range;
  logic              rd_in_range;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  assign op          = din[DATA_W+1:DATA_W];
  assign payload     = din[DATA_W-1:0];
  assign do_write    = rx_valid && (op == OP_WRITE);
  assign do_read     = rx_valid && (op == OP_READ);
  assign wr_in_range = {1'b0, wr_add_reg} < DEPTH_L;
  assign rd_in_range = {1'b0, rd_add_reg} < DEPTH_L;

`ifdef SPI_RAM_AUTO_INC_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  // Wrap at the last populated word, not at 2**ADDR_W, so bursts stay in range.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction
`endif

  always_comb begin
    wr_add_next = wr_add_reg;
    rd_add_next = rd_add_reg;
    if (rx_valid) begin
      case (op)
        OP_SET_WR: wr_add_next = payload[ADDR_W-1:0];
        OP_SET_RD: rd_add_next = payload[ADDR_W-1:0];
`ifdef SPI_RAM_AUTO_INC_EN
        OP_WRITE:  wr_add_next = addr_inc(wr_add_reg);
        OP_READ:   rd_add_next = addr_inc(rd_add_reg);
`endif
        default: ;
      endcase
    end
  end

  // Storage carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (do_write && wr_in_range) begin
      mem[wr_add_reg] <= payload;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      tx_valid   <= 1'b0;
      err        <= 1'b0;
      wr_add_reg <= '0;
      rd_add_reg <= '0;
    end else begin
      tx_valid   <= do_read;
      err        <= (do_write && !wr_in_range) || (do_read && !rd_in_range);
      wr_add_reg <= wr_add_next;
      rd_add_reg <= rd_add_next;
      if (do_read) begin
        dout <= rd_in_range ? mem[rd_add_reg] : '0;
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_ram.sv
// Self-checking bench for spi_cmd_ram (MEM_DEPTH=200); expectations follow SPI_RAM_AUTO_INC_EN.
module tb_spi_cmd_ram;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 200;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic [DW+1:0] din      = '0;
  logic          rx_valid = 1'b0;
  logic [DW-1:0] dout;
  logic          tx_valid;
  logic          err;

  spi_cmd_ram #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .dout(dout), .tx_valid(tx_valid), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        tx;
    logic        e;
    logic [DW-1:0] d;
  } ev_t;

  ev_t           sb[$];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            cyc = 0;
  logic [DW-1:0] m_mem [0:255];
  logic [AW-1:0] m_wr = '0;
  logic [AW-1:0] m_rd = '0;
  logic [DW-1:0] exp_dout = '0;

  always @(posedge clk) cyc++;

  function automatic logic [AW-1:0] m_inc(input logic [AW-1:0] a);
    return (int'(a) == DEPTH - 1) ? '0 : a + AW'(1);
  endfunction

  // Drive one command for one edge; model the expected effect and enqueue any output event.
  task automatic cmd(input logic [1:0] op, input logic [DW-1:0] pl);
    ev_t ev;
    din = {op, pl};
    rx_valid = 1'b1;
    ev.due = cyc + 1;
    ev.tx = 1'b0;
    ev.e = 1'b0;
    ev.d = '0;
    case (op)
      2'b00: m_wr = pl[AW-1:0];
      2'b01: begin
        if (int'(m_wr) < DEPTH) m_mem[m_wr] = pl;
        else begin
          ev.e = 1'b1;
          sb.push_back(ev);
        end
`ifdef SPI_RAM_AUTO_INC_EN
        m_wr = m_inc(m_wr);
`endif
      end
      2'b10: m_rd = pl[AW-1:0];
      default: begin
        ev.tx = 1'b1;
        if (int'(m_rd) < DEPTH) ev.d = m_mem[m_rd];
        else ev.e = 1'b1;
        sb.push_back(ev);
`ifdef SPI_RAM_AUTO_INC_EN
        m_rd = m_inc(m_rd);
`endif
      end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard consumer: every cycle either the head event is due or outputs must be quiet.
  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_tx;
      logic exp_err;
      exp_tx = 1'b0;
      exp_err = 1'b0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        ev_t ev;
        ev = sb.pop_front();
        exp_tx = ev.tx;
        exp_err = ev.e;
        if (ev.tx) exp_dout = ev.d;
      end
      n_cmp++;
      if (tx_valid !== exp_tx) begin
        n_fail++;
        $display("FAIL sb_tx_valid cyc=%0d got=%b exp=%b", cyc, tx_valid, exp_tx);
      end
      n_cmp++;
      if (err !== exp_err) begin
        n_fail++;
        $display("FAIL sb_err cyc=%0d got=%b exp=%b", cyc, err, exp_err);
      end
      n_cmp++;
      if (dout !== exp_dout) begin
        n_fail++;
        $display("FAIL sb_dout cyc=%0d got=%h exp=%h", cyc, dout, exp_dout);
      end
    end
  end

  task automatic test_reset;
    #2;
    n_cmp++;
    if (dout !== '0 || tx_valid !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values got dout=%h tx=%b err=%b exp 00/0/0", dout, tx_valid, err);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    $display("reset released at cyc=%0d", cyc);
  endtask

  task automatic test_basic;
    cmd(2'b00, 8'h12);
    cmd(2'b01, 8'hA5);
    cmd(2'b10, 8'h12);
    cmd(2'b11, 8'h00);
    n_cmp++;
    if (tx_valid !== 1'b1 || dout !== 8'hA5) begin
      n_fail++;
      $display("FAIL basic_read got tx=%b dout=%h exp 1/a5", tx_valid, dout);
    end
    idle(1);
    n_cmp++;
    if (tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_pulse_end got tx=%b exp 0", tx_valid);
    end
    $display("basic write/read dout=%h", dout);
  endtask

  task automatic test_write_then_read;
    cmd(2'b00, 8'h40);
    cmd(2'b10, 8'h40);
    cmd(2'b01, 8'h9E);
    cmd(2'b11, 8'h00);
    n_cmp++;
    if (dout !== 8'h9E) begin
      n_fail++;
      $display("FAIL write_then_read got=%h exp=9e", dout);
    end
    idle(1);
    $display("write-then-read dout=9e checked");
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] exp_b [3];
`ifdef SPI_RAM_AUTO_INC_EN
    exp_b = '{8'h11, 8'h22, 8'h33};
`else
    exp_b = '{8'h33, 8'h33, 8'h33};
`endif
    cmd(2'b00, 8'hC6);
    cmd(2'b01, 8'h11);
    cmd(2'b01, 8'h22);
    cmd(2'b01, 8'h33);
    cmd(2'b10, 8'hC6);
    for (int i = 0; i < 3; i++) begin
      cmd(2'b11, 8'h00);
      n_cmp++;
      if (tx_valid !== 1'b1 || dout !== exp_b[i]) begin
        n_fail++;
        $display("FAIL burst_read%0d got tx=%b dout=%h exp 1/%h", i, tx_valid, dout, exp_b[i]);
      end
      $display("burst read %0d dout=%h", i, dout);
    end
    idle(1);
  endtask

  task automatic test_no_inc_hold;
    logic [DW-1:0] exp_h [2];
`ifdef SPI_RAM_AUTO_INC_EN
    exp_h = '{8'h01, 8'h02};
`else
    exp_h = '{8'h02, 8'h02};
`endif
    cmd(2'b00, 8'h05);
    cmd(2'b01, 8'h01);
    cmd(2'b01, 8'h02);
    cmd(2'b10, 8'h05);
    for (int i = 0; i < 2; i++) begin
      cmd(2'b11, 8'h00);
      n_cmp++;
      if (dout !== exp_h[i]) begin
        n_fail++;
        $display("FAIL addr_hold_read%0d got=%h exp=%h", i, dout, exp_h[i]);
      end
    end
    idle(1);
    $display("address hold/increment reads checked");
  endtask

  task automatic test_range;
    cmd(2'b00, 8'hD0);
    cmd(2'b01, 8'h77);
    n_cmp++;
    if (err !== 1'b1 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL range_write_err got err=%b tx=%b exp 1/0", err, tx_valid);
    end
    cmd(2'b10, 8'hD0);
    n_cmp++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL range_err_pulse got err=%b exp 0", err);
    end
    cmd(2'b11, 8'h00);
    n_cmp++;
    if (err !== 1'b1 || tx_valid !== 1'b1 || dout !== 8'h00) begin
      n_fail++;
      $display("FAIL range_read got err=%b tx=%b dout=%h exp 1/1/00", err, tx_valid, dout);
    end
    cmd(2'b10, 8'h12);
    cmd(2'b11, 8'h00);
    n_cmp++;
    if (dout !== 8'hA5) begin
      n_fail++;
      $display("FAIL range_mem_intact got=%h exp=a5", dout);
    end
    idle(1);
    $display("range check done");
  endtask

  task automatic test_idle;
    din = {2'b11, 8'hFF};
    rx_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (tx_valid !== 1'b0 || dout !== exp_dout) begin
        n_fail++;
        $display("FAIL idle_hold%0d got tx=%b dout=%h exp 0/%h", i, tx_valid, dout, exp_dout);
      end
    end
    $display("idle 10 cycles with opcode 11 on din");
  endtask

  task automatic test_set_rd_only;
    cmd(2'b10, 8'h20);
    rx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (tx_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL set_rd_no_tx%0d got tx=%b exp 0", i, tx_valid);
      end
      @(posedge clk);
      #1;
    end
    $display("SET_RD alone produced no tx_valid");
  endtask

  task automatic test_reset_mid;
    cmd(2'b00, 8'h30);
    cmd(2'b01, 8'hC3);
    cmd(2'b10, 8'h30);
    cmd(2'b11, 8'h00);
    n_cmp++;
    if (tx_valid !== 1'b1 || dout !== 8'hC3) begin
      n_fail++;
      $display("FAIL reset_mid_pre got tx=%b dout=%h exp 1/c3", tx_valid, dout);
    end
    rst_n = 1'b0;
    rx_valid = 1'b0;
    sb.delete();
    #1;
    n_cmp++;
    if (dout !== '0 || tx_valid !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async got dout=%h tx=%b err=%b exp 00/0/0", dout, tx_valid, err);
    end
    m_wr = '0;
    m_rd = '0;
    exp_dout = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cmd(2'b01, 8'h5C);
    cmd(2'b11, 8'h00);
    n_cmp++;
    if (dout !== 8'h5C) begin
      n_fail++;
      $display("FAIL reset_addr_zero got=%h exp=5c", dout);
    end
    idle(2);
    $display("mid-run reset checked");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_write_then_read();
    test_back_to_back();
    test_no_inc_hold();
    test_range();
    test_idle();
    test_set_rd_only();
    test_reset_mid();
    idle(2);
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain got=%0d pending exp=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_cmd_ram.md
Name: spi_cmd_ram

Overview:
- Parametrised single-port command-decoded memory that sits behind the SPI slave.
- Accepts command words on din/rx_valid and returns read data on dout/tx_valid.
- Successor of the fixed 256x8 SPI RAM, generalised in data width, address width and depth.
- Adds address auto-increment for burst transfers, range checking with an error flag, and a clean one-cycle tx_valid pulse.

Parameters:
- DATA_W, 8, width of stored words and of the din payload field.
- ADDR_W, 8, width of the write/read address registers; must be <= DATA_W.
- MEM_DEPTH, 256, number of words; must be <= 2**ADDR_W.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  DATA_W+2  command word: din[DATA_W+1:DATA_W] is the opcode, din[DATA_W-1:0] is the payload.
- rx_valid  input  1  din valid this cycle; one command per asserted cycle.
- dout  output  DATA_W  registered read data.
- tx_valid  output  1  one-cycle pulse qualifying dout.
- err  output  1  one-cycle pulse when an out-of-range address is used.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: dout=0, tx_valid=0, err=0, wr_add=0, rd_add=0. Memory contents are not reset and are undefined until written.
- Reset mid-operation: a read issued in the cycle before reset asserts produces no tx_valid, and all outputs go to their reset values immediately.
- Opcodes are decoded only when rx_valid=1. With rx_valid=0 nothing changes, except that tx_valid and err return to 0.
- 00 SET_WR: wr_add <= payload[ADDR_W-1:0]. No output pulse.
- 01 WRITE: if wr_add < MEM_DEPTH, mem[wr_add] <= payload; otherwise the write is dropped and err pulses. After the write, wr_add auto-increments (see Optional Feature).
- 10 SET_RD: rd_add <= payload[ADDR_W-1:0]. No tx_valid; this differs from the previous generation.
- 11 READ: the command is sampled at edge N. At edge N, dout <= mem[rd_add] (or 0 with err=1 if rd_add >= MEM_DEPTH), and tx_valid=1 for exactly the cycle following edge N. rd_add then auto-increments.
- Latency: READ to tx_valid/dout is 1 clock. dout holds its value until the next READ or reset.
- Back-to-back READs on consecutive cycles give tx_valid high on consecutive cycles with successive addresses. No stall and no ready input; the SPI slave must consume each word within one cycle.
- Write and read addresses are independent. A WRITE followed immediately by a READ of the same address returns the new data (write at edge N, read at edge N+1).
- Wrap-around: an increment from MEM_DEPTH-1 goes to 0, so bursts never reach out-of-range addresses. Only explicit SET_WR/SET_RD payloads can produce err.
- Width rule: payload bits above ADDR_W-1 are ignored for SET_WR/SET_RD.
- err: registered, high for one cycle after the offending command's edge, and independent of tx_valid.

Optional Feature:
- Macro: SPI_RAM_AUTO_INC_EN.
- Defined: wr_add increments after every WRITE and rd_add increments after every READ, with wrap at MEM_DEPTH-1 -> 0.
- Undefined: addresses hold after WRITE/READ and change only via SET_WR/SET_RD, which is compatible with the previous generation's addressing.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: assert rst_n=0 mid-run -> dout=0, tx_valid=0, err=0 asynchronously. After release, a READ of an unwritten address returns X-free data only once that address has been written.
- Basic write/read, defaults: SET_WR 0x12, WRITE 0xA5, SET_RD 0x12, READ -> one cycle later tx_valid=1, dout=0xA5; tx_valid=0 the cycle after.
- Burst with SPI_RAM_AUTO_INC_EN: SET_WR 0xFE, WRITE 0x11, 0x22, 0x33 -> mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33 (wrap). SET_RD 0xFE then 3 back-to-back READs -> tx_valid high for 3 consecutive cycles, dout 0x11, 0x22, 0x33.
- Without the macro: SET_WR 0x05, WRITE 0x01, WRITE 0x02, SET_RD 0x05, READ, READ -> dout=0x02 on both reads.
- Range check, MEM_DEPTH=200: SET_WR 0xD0, WRITE 0x77 -> err pulses 1 cycle and memory is unchanged. SET_RD 0xD0, READ -> tx_valid=1, dout=0, err=1.
- Idle and gaps: rx_valid=0 with opcode 11 held on din for 10 cycles -> tx_valid stays 0 and dout is unchanged.
- SET_RD alone: SET_RD 0x20 -> tx_valid never asserts.
